// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the mandelbrot escape-time controller slice.
package mandelbrot_pkg;

  // Default datapath width of cr/ci/zr/zi (signed two's complement).
  localparam int WIDTH_DEFAULT  = 8;
  // Fractional bits for the default width: values cover [-4.0, 4.0).
  localparam int FRAC           = WIDTH_DEFAULT - 3;
  // Default width of the iteration counter, max_iter and res_iter.
  localparam int ITER_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fractional bits for an arbitrary datapath width (3 integer bits incl. sign).
  function automatic int frac_bits(input int width);
    return width - 3;
  endfunction

endpackage

// File: rtl/mandelbrot_iter_ctrl_step.sv
// Combinational mandelbrot step: z' = z^2 + c, plus escape flag |z|^2 > 4.0.
// The step output wraps in two's complement; escape is judged on the input z.
module mandelbrot_iter_ctrl_step
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] in_cr,
  input  logic [WIDTH-1:0] in_ci,
  input  logic [WIDTH-1:0] in_zr,
  input  logic [WIDTH-1:0] in_zi,
  output logic [WIDTH-1:0] out_zr,
  output logic [WIDTH-1:0] out_zi,
  output logic             size
);

  localparam int FW = frac_bits(WIDTH);
  // Product width: one extra bit so the sum of two squares cannot overflow.
  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] FOUR = PW'(4) << (2 * FW);

  logic signed [PW-1:0]    zr_x;
  logic signed [PW-1:0]    zi_x;
  logic signed [PW-1:0]    zr2;
  logic signed [PW-1:0]    zi2;
  logic signed [PW-1:0]    zrzi;
  logic signed [PW-1:0]    mag;
  logic signed [WIDTH-1:0] re_s;
  logic signed [WIDTH-1:0] im_s;

  // Full-precision products, rescaled back to FW fractional bits with floor rounding.
  always_comb begin
    zr_x   = {{(PW-WIDTH){in_zr[WIDTH-1]}}, in_zr};
    zi_x   = {{(PW-WIDTH){in_zi[WIDTH-1]}}, in_zi};
    zr2    = zr_x * zr_x;
    zi2    = zi_x * zi_x;
    zrzi   = zr_x * zi_x;
    mag    = zr2 + zi2;
    size   = (mag > FOUR);
    // 2*zr*zi >>> FW is folded into a single shift by FW-1.
    re_s   = WIDTH'((zr2 - zi2) >>> FW);
    im_s   = WIDTH'(zrzi >>> (FW - 1));
    out_zr = re_s + in_cr;
    out_zi = im_s + in_ci;
  end

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// Escape-time controller: runs one point c through the step unit until it
// escapes or the iteration limit is reached, then holds the result until taken.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int ITER_W = ITER_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  cr,
  input  logic [WIDTH-1:0]  ci,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              abort,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_escaped,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  cr_q;
  logic [WIDTH-1:0]  ci_q;
  logic [WIDTH-1:0]  zr_q;
  logic [WIDTH-1:0]  zi_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] cnt_q;
  logic [WIDTH-1:0]  step_zr;
  logic [WIDTH-1:0]  step_zi;
  logic              step_size;
  logic              accept;
  logic              at_limit;

  mandelbrot_iter_ctrl_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .in_cr (cr_q),
    .in_ci (ci_q),
    .in_zr (zr_q),
    .in_zi (zi_q),
    .out_zr(step_zr),
    .out_zi(step_zi),
    .size  (step_size)
  );

  assign at_limit = (cnt_q == max_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; abort overrides every transition.
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = !abort;
        accept      = start_valid && !abort;
        if (accept) state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (step_size || at_limit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Job registers: latch c/limit on accept, iterate z in ITER, capture result on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cr_q        <= '0;
      ci_q        <= '0;
      max_q       <= '0;
      zr_q        <= '0;
      zi_q        <= '0;
      cnt_q       <= '0;
      res_iter    <= '0;
      res_escaped <= 1'b0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (accept) begin
            cr_q  <= cr;
            ci_q  <= ci;
            max_q <= max_iter;
            zr_q  <= '0;
            zi_q  <= '0;
            cnt_q <= '0;
          end
        end
        ITER: begin
          // Escape has priority over the limit so a point escaping exactly at
          // max_iter is still reported as escaped.
          if (step_size) begin
            res_escaped <= 1'b1;
            res_iter    <= cnt_q;
          end else if (at_limit) begin
            res_escaped <= 1'b0;
            res_iter    <= cnt_q;
          end else begin
            zr_q  <= step_zr;
            zi_q  <= step_zi;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
